vfifo_sc_fwft_rd: RTL

- Single-clock FIFO with a first-word-fall-through read side: the reader counterpart of a simple write-only storage port.
- Storage is a synchronous RAM (1-cycle read latency, registered read address), fed by a plain write-enable interface.
- A small prefetch stage turns the RAM read into a valid/ready stream with zero-bubble throughput.
- Sits between a producer with `wr_en`/`full` flow control and a streaming consumer.

---
 rtl/vfifo_sc_fwft_rd_pkg.sv | 26 ++
 rtl/vfifo_sc_fwft_rd_skid.sv | 88 ++++++++
 rtl/vfifo_sc_fwft_rd.sv | 125 ++++++++++++
 3 files changed

// File: rtl/vfifo_sc_fwft_rd_pkg.sv
// ---------------------------------------------------------------------------
// vfifo_pkg
// Shared definitions for the single-clock FWFT read-side FIFO.
//   OCC_W   : width of the prefetch occupancy count (0..2 words)
//   occ_e   : occupancy states of the two-entry prefetch buffer
//   clog2_f : ceil(log2(n)) helper used to size small counters
// ---------------------------------------------------------------------------
package vfifo_pkg;

   function automatic int clog2_f(input int n);
      int w;
      w = 0;
      while ((1 << w) < n) w++;
      return w;
   endfunction

   // Three occupancy states (EMPTY, ONE, TWO) fit in two bits.
   localparam int OCC_W = clog2_f(3);

   typedef enum logic [OCC_W-1:0] {
      EMPTY,
      ONE,
      TWO
   } occ_e;

endpackage

// File: rtl/vfifo_sc_fwft_rd_skid.sv
// ---------------------------------------------------------------------------
// vfifo_fwft_skid
// Two-entry prefetch buffer (head + skid) that turns 1-cycle-latency RAM
// read data into a first-word-fall-through valid/ready stream.
//   clk, rst    : clock, synchronous active-high reset
//   load_valid  : RAM read data arrives this cycle
//   load_data   : RAM read data
//   pop         : consumer takes the head word this cycle (rd_valid & rd_ready)
//   occ         : words currently held (0..2)
//   rd_q        : head word
//   rd_valid    : head word present
// ---------------------------------------------------------------------------
module vfifo_fwft_skid
   import vfifo_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load_valid,
   input  logic [DATA_WIDTH-1:0] load_data,
   input  logic                  pop,
   output logic [OCC_W-1:0]      occ,
   output logic [DATA_WIDTH-1:0] rd_q,
   output logic                  rd_valid
);

   occ_e                  occ_q, occ_d;
   logic [DATA_WIDTH-1:0] head_q;
   logic [DATA_WIDTH-1:0] skid_q;
   logic                  head_ld;
   logic                  skid_ld;
   logic                  shift;

   // The read-issue throttle guarantees a load never arrives while two words
   // are held without a pop, so no load is ever lost here.
   always_comb begin
      occ_d   = occ_q;
      head_ld = 1'b0;
      skid_ld = 1'b0;
      shift   = 1'b0;
      case (occ_q)
         EMPTY: begin
            if (load_valid) begin
               head_ld = 1'b1;
               occ_d   = ONE;
            end
         end
         ONE: begin
            case ({load_valid, pop})
               2'b10:   begin skid_ld = 1'b1; occ_d = TWO;   end
               2'b01:   begin                 occ_d = EMPTY; end
               2'b11:   begin head_ld = 1'b1;                end
               default: ;
            endcase
         end
         TWO: begin
            if (pop) begin
               shift = 1'b1;
               if (load_valid) skid_ld = 1'b1;
               else            occ_d   = ONE;
            end
         end
         default: occ_d = EMPTY;
      endcase
   end

   // --- stage boundary: prefetch registers ---
   always_ff @(posedge clk) begin
      if (rst) begin
         occ_q  <= EMPTY;
         head_q <= '0;
      end else begin
         occ_q <= occ_d;
         if (head_ld)    head_q <= load_data;
         else if (shift) head_q <= skid_q;
      end
   end

   always_ff @(posedge clk) begin
      if (skid_ld) skid_q <= load_data;
   end

   assign occ      = occ_q;
   assign rd_q     = head_q;
   assign rd_valid = (occ_q != EMPTY);

endmodule

// File: rtl/vfifo_sc_fwft_rd.sv
// ---------------------------------------------------------------------------
// vfifo_sc_fwft_rd
// Single-clock FIFO: synchronous RAM written through a plain write-enable
// port, read through a two-entry prefetch stage giving a first-word-fall-
// through valid/ready stream with one pop per cycle sustained.
//   clk, rst  : clock, synchronous active-high reset
//   wr_d      : write data
//   wr_en     : write strobe (dropped while full)
//   full      : RAM holds 2^ADDR_WIDTH words
//   rd_q      : head-of-FIFO data, valid while rd_valid
//   rd_valid  : head word present
//   rd_ready  : consumer accepts rd_q
//   level     : words held in RAM + in flight + prefetch
//   err       : (only with VFIFO_SC_FWFT_ERR_EN) sticky overflow / underflow
//               flag, cleared only by rst
// Build option: define VFIFO_SC_FWFT_ERR_EN to add the err port.
// ---------------------------------------------------------------------------
module vfifo_sc_fwft_rd
   import vfifo_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] wr_d,
   input  logic                  wr_en,
   output logic                  full,
   output logic [DATA_WIDTH-1:0] rd_q,
   output logic                  rd_valid,
   input  logic                  rd_ready,
   output logic [ADDR_WIDTH+1:0] level
`ifdef VFIFO_SC_FWFT_ERR_EN
   ,
   output logic                  err
`endif
);

   localparam int DEPTH = 1 << ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   logic [ADDR_WIDTH-1:0] wr_ptr_q, rd_ptr_q;
   logic [ADDR_WIDTH:0]   ram_cnt_q, ram_cnt_d;
   logic                  inflight_q;
   logic [DATA_WIDTH-1:0] ram_rdata_q;
   logic                  full_q, full_d;
   logic [ADDR_WIDTH+1:0] level_q, level_d;
   logic [OCC_W-1:0]      occ;
   logic [OCC_W:0]        occ_nxt;
   logic                  wr_acc, pop, issue;

   assign wr_acc  = wr_en & ~full_q;
   assign pop     = rd_valid & rd_ready;
   // Prefetch occupancy after this edge if nothing new is issued.
   assign occ_nxt = {1'b0, occ} + (OCC_W+1)'(inflight_q) - (OCC_W+1)'(pop);
   // Only issue when the word can land in the prefetch buffer next cycle.
   // ram_cnt counts completed writes, so a word written at this edge is
   // never read at the same edge.
   assign issue   = (ram_cnt_q != '0) && (occ_nxt < (OCC_W+1)'(2));

   assign ram_cnt_d = ram_cnt_q + (ADDR_WIDTH+1)'(wr_acc) - (ADDR_WIDTH+1)'(issue);
   assign full_d    = (ram_cnt_d == (ADDR_WIDTH+1)'(DEPTH));
   assign level_d   = (ADDR_WIDTH+2)'(ram_cnt_d) + (ADDR_WIDTH+2)'(issue)
                    + (ADDR_WIDTH+2)'(occ_nxt);

   // --- stage boundary: RAM write port and registered read data ---
   always_ff @(posedge clk) begin
      if (wr_acc) mem[wr_ptr_q] <= wr_d;
      if (issue)  ram_rdata_q   <= mem[rd_ptr_q];
   end

   // --- stage boundary: pointers, counts and status ---
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         ram_cnt_q  <= '0;
         inflight_q <= 1'b0;
         full_q     <= 1'b0;
         level_q    <= '0;
      end else begin
         if (wr_acc) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (issue)  rd_ptr_q <= rd_ptr_q + 1'b1;
         ram_cnt_q  <= ram_cnt_d;
         inflight_q <= issue;
         full_q     <= full_d;
         level_q    <= level_d;
      end
   end

   vfifo_fwft_skid #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_skid (
      .clk        (clk),
      .rst        (rst),
      .load_valid (inflight_q),
      .load_data  (ram_rdata_q),
      .pop        (pop),
      .occ        (occ),
      .rd_q       (rd_q),
      .rd_valid   (rd_valid)
   );

   assign full  = full_q;
   assign level = level_q;

`ifdef VFIFO_SC_FWFT_ERR_EN
   logic err_q;
   logic had_data_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         err_q      <= 1'b0;
         had_data_q <= 1'b0;
      end else begin
         if (wr_acc) had_data_q <= 1'b1;
         if ((wr_en & full_q) | (rd_ready & ~rd_valid & had_data_q)) err_q <= 1'b1;
      end
   end

   assign err = err_q;
`endif

endmodule
